// File: rtl/xrv_pkg.sv
// Shared definitions for the xrv data-memory slice: FSM states, timer register offsets and a
// byte-enable merge helper.
package xrv_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSramRd,
        StResp,
        StHold
    } dmem_state_e;

    // Word offsets (d_addr[3:2]) inside the timer window
    localparam logic [1:0] MtimeLoOff    = 2'd0;
    localparam logic [1:0] MtimeHiOff    = 2'd1;
    localparam logic [1:0] MtimecmpLoOff = 2'd2;
    localparam logic [1:0] MtimecmpHiOff = 2'd3;

    function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/xrv_timer.sv
// Machine timer: free-running 64-bit mtime, mtimecmp, coherent hi-word shadow and registered irq.
module xrv_timer
    import xrv_pkg::*;
(
    input  logic        clk,
    input  logic        rstb,
    input  logic [1:0]  off,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    logic [63:0] mtime_q;
    logic [63:0] cmp_q;
    logic [31:0] shadow_q;
    logic        irq_q;

    always_ff @(posedge clk) begin
        if (rstb) begin
            mtime_q  <= '0;
            cmp_q    <= '1;
            shadow_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            mtime_q <= mtime_q + 64'd1;
            irq_q   <= (mtime_q >= cmp_q);
            // Latching the hi word on a lo read makes a lo-then-hi sequence coherent
            if (rd_en && off == MtimeLoOff) shadow_q <= mtime_q[63:32];
            if (wr_en && off == MtimecmpLoOff) cmp_q[31:0]  <= apply_be(cmp_q[31:0], wdata, be);
            if (wr_en && off == MtimecmpHiOff) cmp_q[63:32] <= apply_be(cmp_q[63:32], wdata, be);
        end
    end

    always_comb begin
        rdata = '0;
        unique case (off)
            MtimeLoOff:    rdata = mtime_q[31:0];
            MtimeHiOff:    rdata = shadow_q;
            MtimecmpLoOff: rdata = cmp_q[31:0];
            MtimecmpHiOff: rdata = cmp_q[63:32];
            default:       rdata = '0;
        endcase
    end

    assign irq = irq_q;

endmodule

// File: rtl/xrv_dmem.sv
// Data-side memory controller: decodes core accesses to SRAM, the timer window or nowhere, and
// sequences them through a four-state handshake FSM.
module xrv_dmem
    import xrv_pkg::*;
#(
    parameter int unsigned DMEM_AW   = 12,
    parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic [31:0]        d_addr,
    input  logic               d_wr_req,
    input  logic               d_rd_req,
    input  logic [3:0]         d_be,
    input  logic [31:0]        d_wr_data,
    output logic               d_wr_ready,
    output logic               d_rd_ready,
    output logic [31:0]        d_rd_data,
    output logic               m_cs,
    output logic               m_we,
    output logic [DMEM_AW-1:0] m_addr,
    output logic [3:0]         m_be,
    output logic [31:0]        m_wdata,
    input  logic [31:0]        m_rdata,
    output logic               timer_irq,
    output logic               err
);

    dmem_state_e state_q, state_d;
    logic        is_wr_q, is_wr_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        err_q, err_d;

    logic        is_sram, is_mmio;
    logic        t_rd, t_wr;
    logic [31:0] t_rdata;
    logic        unused_addr;

    assign is_sram     = (d_addr[31:DMEM_AW+2] == '0);
    assign is_mmio     = (d_addr[31:4] == MMIO_BASE[31:4]);
    assign unused_addr = ^d_addr[1:0];

    xrv_timer u_timer (
        .clk   (clk),
        .rstb  (rstb),
        .off   (d_addr[3:2]),
        .rd_en (t_rd),
        .wr_en (t_wr),
        .be    (d_be),
        .wdata (d_wr_data),
        .rdata (t_rdata),
        .irq   (timer_irq)
    );

    always_ff @(posedge clk) begin
        if (rstb) begin
            state_q   <= StIdle;
            is_wr_q   <= 1'b0;
            rd_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_wr_q   <= is_wr_d;
            rd_data_q <= rd_data_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        is_wr_d   = is_wr_q;
        rd_data_d = rd_data_q;
        err_d     = err_q;
        m_cs      = 1'b0;
        m_we      = 1'b0;
        m_addr    = '0;
        m_be      = '0;
        m_wdata   = '0;
        t_rd      = 1'b0;
        t_wr      = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Accepting during reset would leak an SRAM strobe or timer side effect
                if (!rstb && d_wr_req) begin
                    is_wr_d = 1'b1;
                    state_d = StResp;
                    if (d_rd_req) err_d = 1'b1;
                    if (is_sram) begin
                        m_cs    = 1'b1;
                        m_we    = 1'b1;
                        m_addr  = d_addr[DMEM_AW+1:2];
                        m_be    = d_be;
                        m_wdata = d_wr_data;
                    end else if (is_mmio) begin
                        t_wr = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (!rstb && d_rd_req) begin
                    is_wr_d = 1'b0;
                    if (is_sram) begin
                        m_cs    = 1'b1;
                        m_addr  = d_addr[DMEM_AW+1:2];
                        state_d = StSramRd;
                    end else begin
                        state_d = StResp;
                        if (is_mmio) begin
                            t_rd      = 1'b1;
                            rd_data_d = t_rdata;
                        end else begin
                            rd_data_d = '0;
                            err_d     = 1'b1;
                        end
                    end
                end
            end
            StSramRd: begin
                rd_data_d = m_rdata;
                state_d   = StResp;
            end
            StResp: begin
                state_d = StHold;
            end
            StHold: begin
                if (!d_wr_req && !d_rd_req) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign d_wr_ready = (state_q == StResp) && is_wr_q;
    assign d_rd_ready = (state_q == StResp) && !is_wr_q;
    assign d_rd_data  = rd_data_q;
    assign err        = err_q;

endmodule

// File: tb/tb_xrv_dmem.sv
// Directed bench for xrv_dmem with a behavioural single-port SRAM and an mtime reference counter.
module tb_xrv_dmem;

    logic        clk = 1'b0;
    logic        rstb;
    logic [31:0] d_addr;
    logic        d_wr_req, d_rd_req;
    logic [3:0]  d_be;
    logic [31:0] d_wr_data;
    logic        d_wr_ready, d_rd_ready;
    logic [31:0] d_rd_data;
    logic        m_cs, m_we;
    logic [11:0] m_addr;
    logic [3:0]  m_be;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata = '0;
    logic        timer_irq;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;
    int cs_cnt   = 0;
    logic [63:0] tb_mtime = '0;
    logic [31:0] mem [0:4095];

    always #5 clk = ~clk;

    xrv_dmem dut (
        .clk        (clk),
        .rstb       (rstb),
        .d_addr     (d_addr),
        .d_wr_req   (d_wr_req),
        .d_rd_req   (d_rd_req),
        .d_be       (d_be),
        .d_wr_data  (d_wr_data),
        .d_wr_ready (d_wr_ready),
        .d_rd_ready (d_rd_ready),
        .d_rd_data  (d_rd_data),
        .m_cs       (m_cs),
        .m_we       (m_we),
        .m_addr     (m_addr),
        .m_be       (m_be),
        .m_wdata    (m_wdata),
        .m_rdata    (m_rdata),
        .timer_irq  (timer_irq),
        .err        (err)
    );

    always @(posedge clk) begin
        if (m_cs) begin
            cs_cnt <= cs_cnt + 1;
            if (m_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (m_be[b]) mem[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
                end
            end else begin
                m_rdata <= mem[m_addr];
            end
        end
    end

    always @(posedge clk) tb_mtime <= rstb ? 64'd0 : tb_mtime + 64'd1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic xact(input logic wr, input logic rd, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input int hold,
                        output logic [31:0] rdata, output int lat, output int rdy_cnt,
                        output logic was_wr);
        d_addr = addr; d_wr_data = wdata; d_be = be; d_wr_req = wr; d_rd_req = rd;
        lat = 99; rdy_cnt = 0; rdata = '0; was_wr = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (d_wr_ready || d_rd_ready) begin
                lat = i; rdy_cnt++; rdata = d_rd_data; was_wr = d_wr_ready;
                break;
            end
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (d_wr_ready || d_rd_ready) rdy_cnt++;
        end
        d_wr_req = 1'b0; d_rd_req = 1'b0;
        @(negedge clk);
        if (d_wr_ready || d_rd_ready) rdy_cnt++;
        @(negedge clk);
        if (d_wr_ready || d_rd_ready) rdy_cnt++;
    endtask

    initial begin
        logic [31:0] rd;
        int lat, rdy, cs0;
        logic ww;
        logic [63:0] exp_mt;

        rstb = 1'b1; d_addr = '0; d_wr_req = 1'b0; d_rd_req = 1'b0; d_be = '0; d_wr_data = '0;
        repeat (3) @(negedge clk);
        check("rst_wr_ready", d_wr_ready, 0);
        check("rst_rd_ready", d_rd_ready, 0);
        check("rst_rd_data", d_rd_data, 0);
        check("rst_m_cs", m_cs, 0);
        check("rst_err", err, 0);
        check("rst_irq", timer_irq, 0);
        rstb = 1'b0;

        xact(1, 0, 32'h100, 32'hDEADBEEF, 4'hF, 0, rd, lat, rdy, ww);
        check("sram_wr_lat", lat, 1);
        check("sram_wr_rdy", rdy, 1);
        xact(0, 1, 32'h100, 32'h0, 4'h0, 0, rd, lat, rdy, ww);
        check("sram_rd_lat", lat, 2);
        check("sram_rd_data", rd, 32'hDEADBEEF);

        xact(1, 0, 32'h104, 32'hFFFFFFFF, 4'hF, 0, rd, lat, rdy, ww);
        xact(1, 0, 32'h104, 32'h11223344, 4'b0101, 0, rd, lat, rdy, ww);
        xact(0, 1, 32'h104, 32'h0, 4'h0, 0, rd, lat, rdy, ww);
        check("be_merge", rd, 32'hFF22FF44);

        cs0 = cs_cnt;
        xact(1, 0, 32'h108, 32'hA5A5A5A5, 4'hF, 5, rd, lat, rdy, ww);
        check("hold_wr_rdy", rdy, 1);
        check("hold_wr_cs", cs_cnt - cs0, 1);
        cs0 = cs_cnt;
        xact(0, 1, 32'h108, 32'h0, 4'h0, 5, rd, lat, rdy, ww);
        check("hold_rd_rdy", rdy, 1);
        check("hold_rd_cs", cs_cnt - cs0, 1);
        check("hold_rd_data", rd, 32'hA5A5A5A5);

        xact(0, 1, 32'h8000_0008, 32'h0, 4'h0, 0, rd, lat, rdy, ww);
        check("cmp_lo_reset", rd, 32'hFFFFFFFF);
        check("mmio_rd_lat", lat, 1);
        xact(1, 0, 32'h8000_0008, 32'hAABBCCDD, 4'b0011, 0, rd, lat, rdy, ww);
        check("mmio_wr_lat", lat, 1);
        xact(0, 1, 32'h8000_0008, 32'h0, 4'h0, 0, rd, lat, rdy, ww);
        check("cmp_lo_be", rd, 32'hFFFFCCDD);
        xact(1, 0, 32'h8000_0000, 32'h12345678, 4'hF, 0, rd, lat, rdy, ww);
        check("mtime_wr_no_err", err, 0);

        xact(1, 0, 32'h0, 32'h12345678, 4'hF, 0, rd, lat, rdy, ww);
        xact(0, 1, 32'h4000_0000, 32'h0, 4'h0, 0, rd, lat, rdy, ww);
        check("unmap_rd_data", rd, 0);
        check("unmap_rd_lat", lat, 1);
        check("unmap_err", err, 1);
        cs0 = cs_cnt;
        xact(1, 0, 32'h4000_0000, 32'hCAFEF00D, 4'hF, 0, rd, lat, rdy, ww);
        check("unmap_wr_lat", lat, 1);
        check("unmap_wr_cs", cs_cnt - cs0, 0);
        xact(0, 1, 32'h0, 32'h0, 4'h0, 0, rd, lat, rdy, ww);
        check("unmap_wr_sram_kept", rd, 32'h12345678);

        // Reset lands while the SRAM read is in flight
        d_addr = 32'h100; d_rd_req = 1'b1;
        @(negedge clk);
        rstb = 1'b1; d_rd_req = 1'b0;
        @(negedge clk);
        check("abort_no_rdy", d_rd_ready, 0);
        check("abort_rd_data", d_rd_data, 0);
        rstb = 1'b0;
        @(negedge clk);
        check("abort_no_rdy2", d_rd_ready, 0);
        check("abort_err_clr", err, 0);
        xact(0, 1, 32'h8000_0008, 32'h0, 4'h0, 0, rd, lat, rdy, ww);
        check("abort_cmp_lo", rd, 32'hFFFFFFFF);
        xact(0, 1, 32'h8000_000C, 32'h0, 4'h0, 0, rd, lat, rdy, ww);
        check("abort_cmp_hi", rd, 32'hFFFFFFFF);
        xact(0, 1, 32'h100, 32'h0, 4'h0, 0, rd, lat, rdy, ww);
        check("post_abort_lat", lat, 2);

        xact(1, 0, 32'h8000_000C, 32'h0, 4'hF, 0, rd, lat, rdy, ww);
        xact(1, 0, 32'h8000_0008, 32'd50, 4'hF, 0, rd, lat, rdy, ww);
        check("irq_low_early", timer_irq, 0);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (timer_irq) break;
        end
        check("irq_rise", timer_irq, 1);
        check("irq_rise_time", tb_mtime, 64'd51);

        exp_mt = tb_mtime;
        xact(0, 1, 32'h8000_0000, 32'h0, 4'h0, 0, rd, lat, rdy, ww);
        check("mtime_lo", rd, exp_mt[31:0]);
        xact(0, 1, 32'h8000_0004, 32'h0, 4'h0, 0, rd, lat, rdy, ww);
        check("mtime_hi_shadow", rd, exp_mt[63:32]);

        xact(1, 1, 32'h200, 32'h0BADF00D, 4'hF, 0, rd, lat, rdy, ww);
        check("both_is_wr", ww, 1);
        check("both_rdy", rdy, 1);
        check("both_err", err, 1);
        xact(0, 1, 32'h200, 32'h0, 4'h0, 0, rd, lat, rdy, ww);
        check("both_wr_data", rd, 32'h0BADF00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/xrv_dmem.md
XRV_DMEM -- requirements
Module: xrv_dmem

Interface
REQ-001 Parameter DMEM_AW, default 12, SHALL set the SRAM word-address width (16 KiB of data RAM).
REQ-002 Parameter MMIO_BASE, default 32'h8000_0000, SHALL set the base byte address of the timer register window.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rstb  input  1  synchronous, active-high reset.
REQ-005 d_addr  input  32  core data byte address; bits [1:0] ignored.
REQ-006 d_wr_req / d_rd_req  input  1 each  core write/read request, held until the matching ready.
REQ-007 d_be  input  4  write byte enables; d_wr_data  input  32  write data.
REQ-008 d_wr_ready / d_rd_ready  output  1 each  single-cycle completion pulse.
REQ-009 d_rd_data  output  32  registered read data, valid while d_rd_ready=1.
REQ-010 m_cs, m_we  output  1 each; m_addr  output  DMEM_AW; m_be  output  4; m_wdata  output  32; m_rdata  input  32: single-port SRAM, read data valid one cycle after m_cs&!m_we.
REQ-011 timer_irq  output  1  registered machine-timer interrupt level.
REQ-012 err  output  1  sticky flag, set by any access to an unmapped address.

Function
REQ-013 FSM states SHALL be IDLE, SRAM_RD, RESP, HOLD.
REQ-014 Decode: SRAM when d_addr[31:DMEM_AW+2]==0; MMIO when d_addr[31:4]==MMIO_BASE[31:4]; otherwise unmapped.
REQ-015 IDLE with d_wr_req: write wins over a simultaneous d_rd_req, sets err, and is handled as a write.
REQ-016 IDLE, SRAM write: m_cs=m_we=1, m_addr=d_addr[DMEM_AW+1:2], m_be=d_be, m_wdata=d_wr_data, all combinational in the same cycle; next state RESP.
REQ-017 IDLE, SRAM read: m_cs=1, m_we=0; next state SRAM_RD, which captures m_rdata into d_rd_data; next state RESP.
REQ-018 IDLE, MMIO or unmapped access: performed in IDLE; next state RESP.
REQ-019 Unmapped access: reads return 32'h0, writes are dropped, and err is set.
REQ-020 RESP: assert exactly one of d_wr_ready/d_rd_ready for one cycle; next state HOLD.
REQ-021 HOLD: wait until both d_wr_req and d_rd_req are 0, then go to IDLE.
REQ-022 No request SHALL be accepted in HOLD.
REQ-023 Latency, measured from the cycle a request is sampled in IDLE:
  - SRAM read: ready at +2.
  - Everything else: ready at +1.
REQ-024 m_cs SHALL be 0 in every state except IDLE-accept.
REQ-025 MMIO map, byte offsets:
  - 0x0: mtime_lo, read-only.
  - 0x4: mtime_hi, read-only; returns the shadow.
  - 0x8: mtimecmp_lo, read/write.
  - 0xC: mtimecmp_hi, read/write.
REQ-026 Reading mtime_lo SHALL latch mtime[63:32] into a shadow register, so a lo-then-hi read sequence is coherent.
REQ-027 mtimecmp writes SHALL honour d_be per byte; writes to offsets 0x0/0x4 are ignored without setting err.
REQ-028 mtime is 64-bit, increments by 1 every cycle, and wraps from 2^64-1 to 0.
REQ-029 timer_irq SHALL equal the registered value of (mtime >= mtimecmp), updating the cycle after any change.
REQ-030 d_rd_data SHALL hold its last value outside RESP.

Reset
REQ-031 While rstb=1, the following SHALL hold next cycle:
  - state=IDLE; d_rd_data=0; all readies=0; m_cs=m_we=0.
  - mtime=0; shadow=0; mtimecmp=64'hFFFF_FFFF_FFFF_FFFF; timer_irq=0; err=0.
REQ-032 Reset asserted mid-transaction SHALL abort it with no ready pulse; the core re-issues.

Structure
REQ-033 The FSM state enum and the MMIO offset constants SHALL live in the shared package xrv_pkg.
REQ-034 mtime, mtimecmp, shadow and the irq compare SHALL be one sub-module, xrv_timer; the decode and FSM stay in xrv_dmem.

Verification
REQ-035 SRAM write then read:
  - Write 0xDEADBEEF to 0x100 with be=4'hF -> d_wr_ready at +1.
  - Read 0x100 -> d_rd_ready at +2 with data 0xDEADBEEF.
REQ-036 Byte enables: write 0x11223344 with be=4'b0101 over 0xFFFFFFFF -> read returns 0xFF22FF44.
REQ-037 Timer:
  - Write mtimecmp_hi=0, then mtimecmp_lo=50 -> timer_irq rises the cycle after mtime reaches 50.
  - Read lo then hi -> hi returns the value shadowed at the lo read.
REQ-038 Unmapped address 0x4000_0000:
  - Read -> data 0 with ready at +1, err=1.
  - Write -> ready at +1, SRAM untouched.
REQ-039 Request held 5 cycles after ready -> exactly one ready pulse and one SRAM access; no re-accept until the request drops.
REQ-040 rstb raised in the SRAM_RD cycle -> no d_rd_ready; state IDLE; mtimecmp reads back all-ones.
